// File: rtl/regfile_wr_arbiter.sv
// Shares the single register-file write port between an ALU and a load writeback requester.
// Each requester has a one-entry slot; a round-robin arbiter issues at most one write per cycle.
module regfile_wr_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int DROP_R0 = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_reg,
  input  logic [DW-1:0]    a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_reg,
  input  logic [DW-1:0]    b_data,
  output logic             enwr,
  output logic [AW-1:0]    regNum,
  output logic [DW-1:0]    wrdata,
  input  logic [AW-1:0]    Rreg1,
  input  logic [AW-1:0]    Rreg2,
  output logic             hz1,
  output logic             hz2,
  output logic [CNT_W-1:0] wr_count
);

  logic             full_a_reg, full_b_reg;
  logic [AW-1:0]    a_slot_num_reg, b_slot_num_reg;
  logic [DW-1:0]    a_slot_data_reg, b_slot_data_reg;
  logic             last_grant_b_reg;
  logic             enwr_reg;
  logic [AW-1:0]    regnum_reg;
  logic [DW-1:0]    wrdata_reg;
  logic [CNT_W-1:0] wr_count_reg;

  logic             grant_a, grant_b, grant_any;
  logic [AW-1:0]    sel_num;
  logic [DW-1:0]    sel_data;
  logic             sel_drop;

  // Grant depends only on registered slot state, so ready never sees a valid input.
  assign grant_a   = full_a_reg & (~full_b_reg | last_grant_b_reg);
  assign grant_b   = full_b_reg & (~full_a_reg | ~last_grant_b_reg);
  assign grant_any = grant_a | grant_b;

  assign a_ready = ~full_a_reg | grant_a;
  assign b_ready = ~full_b_reg | grant_b;

  always_comb begin
    sel_num  = b_slot_num_reg;
    sel_data = b_slot_data_reg;
    if (grant_a) begin
      sel_num  = a_slot_num_reg;
      sel_data = a_slot_data_reg;
    end
    sel_drop = (DROP_R0 != 0) && (sel_num == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_a_reg       <= 1'b0;
      full_b_reg       <= 1'b0;
      a_slot_num_reg   <= '0;
      b_slot_num_reg   <= '0;
      a_slot_data_reg  <= '0;
      b_slot_data_reg  <= '0;
      last_grant_b_reg <= 1'b1;
      enwr_reg         <= 1'b0;
      regnum_reg       <= '0;
      wrdata_reg       <= '0;
      wr_count_reg     <= '0;
    end else begin
      if (a_valid && a_ready) begin
        full_a_reg      <= 1'b1;
        a_slot_num_reg  <= a_reg;
        a_slot_data_reg <= a_data;
      end else if (grant_a) begin
        full_a_reg <= 1'b0;
      end

      if (b_valid && b_ready) begin
        full_b_reg      <= 1'b1;
        b_slot_num_reg  <= b_reg;
        b_slot_data_reg <= b_data;
      end else if (grant_b) begin
        full_b_reg <= 1'b0;
      end

      if (grant_any) begin
        last_grant_b_reg <= grant_b;
      end

      // A dropped register-0 write still consumes its grant but never reaches the port.
      enwr_reg <= grant_any & ~sel_drop;
      if (grant_any && !sel_drop) begin
        regnum_reg   <= sel_num;
        wrdata_reg   <= sel_data;
        wr_count_reg <= wr_count_reg + CNT_W'(1);
      end
    end
  end

  assign enwr     = enwr_reg;
  assign regNum   = regnum_reg;
  assign wrdata   = wrdata_reg;
  assign wr_count = wr_count_reg;

  logic [AW-1:0] rd_addr [2];
  logic [1:0]    hz;

  assign rd_addr[0] = Rreg1;
  assign rd_addr[1] = Rreg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
      assign hz[gi] = ((full_a_reg && a_slot_num_reg == rd_addr[gi]) ||
                       (full_b_reg && b_slot_num_reg == rd_addr[gi])) &&
                      !((DROP_R0 != 0) && (rd_addr[gi] == '0));
    end
  endgenerate

  assign hz1 = hz[0];
  assign hz2 = hz[1];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, streaming, arbitration, r0 drop,
// hazard flags and asynchronous reset in flight.
module tb_regfile_wr_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rstn;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic [AW-1:0]    a_reg, b_reg;
  logic [DW-1:0]    a_data, b_data;
  logic             enwr;
  logic [AW-1:0]    regNum;
  logic [DW-1:0]    wrdata;
  logic [AW-1:0]    Rreg1, Rreg2;
  logic             hz1, hz2;
  logic [CNT_W-1:0] wr_count;

  int checks   = 0;
  int failures = 0;

  regfile_wr_arbiter #(.DW(DW), .AW(AW), .DROP_R0(1), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .enwr     (enwr),
    .regNum   (regNum),
    .wrdata   (wrdata),
    .Rreg1    (Rreg1),
    .Rreg2    (Rreg2),
    .hz1      (hz1),
    .hz2      (hz2),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    Rreg1 = '0; Rreg2 = '0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    Rreg1 = 5'd7; Rreg2 = 5'd9;
    rstn = 1'b0;
    tick();
    tick();
    checks++; if (enwr !== 1'b0) begin failures++; $display("FAIL reset_enwr: got %b want 0", enwr); end
    checks++; if (regNum !== 5'd0) begin failures++; $display("FAIL reset_regNum: got %0d want 0", regNum); end
    checks++; if (wrdata !== 32'd0) begin failures++; $display("FAIL reset_wrdata: got %0h want 0", wrdata); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
    checks++; if (hz1 !== 1'b0 || hz2 !== 1'b0) begin failures++; $display("FAIL reset_hz: got %b%b want 00", hz1, hz2); end
    checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    rstn = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] nums [3];
    logic [DW-1:0] vals [3];
    nums[0] = 5'd10; nums[1] = 5'd14; nums[2] = 5'd19;
    vals[0] = 32'd64; vals[1] = 32'd31; vals[2] = 32'd45;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_reg = nums[i]; a_data = vals[i];
      checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_a_ready[%0d]: got %b want 1", i, a_ready); end
      tick();
      if (i == 0) begin
        checks++; if (enwr !== 1'b0) begin failures++; $display("FAIL b2b_latency: got enwr=%b want 0 one edge after accept", enwr); end
      end else begin
        checks++; if (enwr !== 1'b1 || regNum !== nums[i-1] || wrdata !== vals[i-1]) begin
          failures++; $display("FAIL b2b_issue[%0d]: got enwr=%b r%0d=%0d want enwr=1 r%0d=%0d", i-1, enwr, regNum, wrdata, nums[i-1], vals[i-1]);
        end
        $display("b2b issue: r%0d=%0d", regNum, wrdata);
      end
    end
    a_valid = 1'b0;
    tick();
    checks++; if (enwr !== 1'b1 || regNum !== 5'd19 || wrdata !== 32'd45) begin
      failures++; $display("FAIL b2b_issue[2]: got enwr=%b r%0d=%0d want enwr=1 r19=45", enwr, regNum, wrdata);
    end
    $display("b2b issue: r%0d=%0d", regNum, wrdata);
    tick();
    checks++; if (enwr !== 1'b0) begin failures++; $display("FAIL b2b_idle_enwr: got %b want 0", enwr); end
    checks++; if (regNum !== 5'd19 || wrdata !== 32'd45) begin failures++; $display("FAIL b2b_hold: got r%0d=%0d want r19=45", regNum, wrdata); end
    checks++; if (wr_count !== 16'd3) begin failures++; $display("FAIL b2b_wr_count: got %0d want 3", wr_count); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_num [4];
    logic [DW-1:0] exp_val [4];
    exp_num[0] = 5'd14; exp_num[1] = 5'd19; exp_num[2] = 5'd14; exp_num[3] = 5'd19;
    exp_val[0] = 32'd31; exp_val[1] = 32'd45; exp_val[2] = 32'd31; exp_val[3] = 32'd45;
    apply_reset();
    a_valid = 1'b1; a_reg = 5'd14; a_data = 32'd31;
    b_valid = 1'b1; b_reg = 5'd19; b_data = 32'd45;
    tick();
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failures++; $display("FAIL rr_first_tie: got a_ready=%b b_ready=%b want 1 0", a_ready, b_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (enwr !== 1'b1 || regNum !== exp_num[k] || wrdata !== exp_val[k]) begin
        failures++; $display("FAIL rr_grant[%0d]: got enwr=%b r%0d=%0d want enwr=1 r%0d=%0d", k, enwr, regNum, wrdata, exp_num[k], exp_val[k]);
      end
      $display("rr issue %0d: r%0d=%0d", k, regNum, wrdata);
    end
    checks++; if (wr_count !== 16'd4) begin failures++; $display("FAIL rr_wr_count: got %0d want 4", wr_count); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_drop_r0();
    apply_reset();
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF_FFFF;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL r0_a_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0;
    Rreg1 = 5'd0; Rreg2 = 5'd0;
    #1;
    checks++; if (hz1 !== 1'b0 || hz2 !== 1'b0) begin failures++; $display("FAIL r0_hz_masked: got %b%b want 00", hz1, hz2); end
    tick();
    checks++; if (enwr !== 1'b0) begin failures++; $display("FAIL r0_enwr: got %b want 0", enwr); end
    checks++; if (wr_count !== 16'd0 || wrdata !== 32'd0) begin
      failures++; $display("FAIL r0_no_issue: got count=%0d wrdata=%0h want 0 0", wr_count, wrdata);
    end
    tick();
    checks++; if (enwr !== 1'b0) begin failures++; $display("FAIL r0_enwr_late: got %b want 0", enwr); end
    $display("r0 write accepted and discarded");
  endtask

  task automatic test_hazard();
    apply_reset();
    Rreg1 = 5'd10; Rreg2 = 5'd14;
    a_valid = 1'b1; a_reg = 5'd3;  a_data = 32'd7;
    b_valid = 1'b1; b_reg = 5'd10; b_data = 32'd5;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (hz1 !== 1'b1 || hz2 !== 1'b0) begin failures++; $display("FAIL hz_both_full: got %b%b want 10", hz1, hz2); end
    Rreg2 = 5'd3;
    #1;
    checks++; if (hz2 !== 1'b1) begin failures++; $display("FAIL hz2_a_slot: got %b want 1", hz2); end
    Rreg2 = 5'd14;
    tick();
    checks++; if (enwr !== 1'b1 || regNum !== 5'd3) begin failures++; $display("FAIL hz_a_issue: got enwr=%b r%0d want 1 r3", enwr, regNum); end
    checks++; if (hz1 !== 1'b1 || hz2 !== 1'b0) begin failures++; $display("FAIL hz_b_pending: got %b%b want 10", hz1, hz2); end
    tick();
    checks++; if (enwr !== 1'b1 || regNum !== 5'd10 || wrdata !== 32'd5) begin
      failures++; $display("FAIL hz_b_issue: got enwr=%b r%0d=%0d want 1 r10=5", enwr, regNum, wrdata);
    end
    checks++; if (hz1 !== 1'b0) begin failures++; $display("FAIL hz1_drop: got %b want 0", hz1); end
    $display("hazard: b r10 issued, hz1=%b", hz1);
  endtask

  task automatic test_async_reset();
    apply_reset();
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'd1;
    b_valid = 1'b1; b_reg = 5'd6; b_data = 32'd2;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    checks++; if (enwr !== 1'b1 || wr_count !== 16'd1) begin
      failures++; $display("FAIL ar_pre: got enwr=%b count=%0d want 1 1", enwr, wr_count);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (enwr !== 1'b0 || regNum !== 5'd0 || wrdata !== 32'd0 || wr_count !== 16'd0) begin
      failures++; $display("FAIL ar_clear: got enwr=%b r%0d=%0d count=%0d want 0 r0=0 0", enwr, regNum, wrdata, wr_count);
    end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      failures++; $display("FAIL ar_ready: got %b%b want 11", a_ready, b_ready);
    end
    #2;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (enwr !== 1'b0 || wr_count !== 16'd0) begin
        failures++; $display("FAIL ar_after[%0d]: got enwr=%b count=%0d want 0 0", k, enwr, wr_count);
      end
    end
    $display("async reset: pending slot discarded");
  endtask

  initial begin
    rstn = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    Rreg1 = '0; Rreg2 = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_round_robin();
    test_drop_r0();
    test_hazard();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
